// File: rtl/pin_lock_pkg.sv
// Shared state encoding, key codes and key classification for the PIN lock controller.
package pin_lock_pkg;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT,
    NEWPIN
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;
  localparam logic [3:0] KEY_CHG  = 4'hA;

  function automatic logic is_digit(input logic [3:0] num);
    return num <= 4'h9;
  endfunction

endpackage

// File: rtl/pin_lock_ctrl_lockout_timer.sv
// Loadable down-counter; done flags the final cycle of a running count.
module lockout_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = run && (count == '0);

endmodule

// File: rtl/pin_lock_ctrl.sv
// PIN entry/compare FSM with failure counting and timed lockout.
// PIN_LOCK_PIN_CHANGE_EN adds a NEWPIN state reachable from OPEN with key 'A'.
module pin_lock_ctrl
  import pin_lock_pkg::*;
#(
  parameter int              PIN_LEN     = 4,
  parameter logic [15:0]     DEFAULT_PIN = 16'h1234,
  parameter int              MAX_FAIL    = 3,
  parameter int unsigned     LOCK_CYCLES = 32'd500_000_000,
  parameter int              CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        keyboard_en,
  input  logic [3:0]  keyboard_num,
  output logic        en,
  output logic        locked_out,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt,
  output logic [1:0]  fail_cnt,
  output logic        err_pulse
);

  localparam int               PW        = 4 * PIN_LEN;
  localparam logic [2:0]       LEN       = 3'(PIN_LEN);
  localparam logic [2:0]       MAXF3     = 3'(MAX_FAIL);
  localparam logic [1:0]       MAXF2     = 2'(MAX_FAIL);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] entry_d;
  logic [2:0]  cnt_d;
  logic [1:0]  fail_d;
  logic        err_d;
  logic        timer_load;
  logic        timer_done;
  logic [15:0] pin_reg;

`ifdef PIN_LOCK_PIN_CHANGE_EN
  logic pin_wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      pin_reg <= DEFAULT_PIN;
    end else if (pin_wr) begin
      pin_reg <= entry;
    end
  end
`else
  assign pin_reg = DEFAULT_PIN;
`endif

  lockout_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .run      (state_q == LOCKOUT),
    .load_val (LOCK_LOAD),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ENTRY;
      entry      <= '0;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      err_pulse  <= 1'b0;
      en         <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      entry      <= entry_d;
      digit_cnt  <= cnt_d;
      fail_cnt   <= fail_d;
      err_pulse  <= err_d;
      en         <= (state_d == OPEN) || (state_d == NEWPIN);
      locked_out <= (state_d == LOCKOUT);
    end
  end

  always_comb begin
    state_d    = state_q;
    entry_d    = entry;
    cnt_d      = digit_cnt;
    fail_d     = fail_cnt;
    err_d      = 1'b0;
    timer_load = 1'b0;
`ifdef PIN_LOCK_PIN_CHANGE_EN
    pin_wr     = 1'b0;
`endif
    case (state_q)
      ENTRY, NEWPIN: begin
        if (keyboard_en) begin
          if (is_digit(keyboard_num)) begin
            if (digit_cnt != LEN) begin
              entry_d = {entry[11:0], keyboard_num};
              cnt_d   = digit_cnt + 3'd1;
            end
          end else if (keyboard_num == KEY_STAR) begin
            entry_d = '0;
            cnt_d   = '0;
            if (state_q == NEWPIN) state_d = OPEN;
          end else if (keyboard_num == KEY_HASH) begin
            if (digit_cnt != LEN) begin
              err_d   = 1'b1;
              entry_d = '0;
              cnt_d   = '0;
            end else if (state_q == ENTRY) begin
              // entry is held through CHECK for the comparison
              state_d = CHECK;
            end
`ifdef PIN_LOCK_PIN_CHANGE_EN
            else begin
              pin_wr  = 1'b1;
              entry_d = '0;
              cnt_d   = '0;
              state_d = OPEN;
            end
`endif
          end
        end
      end
      CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry[PW-1:0] == pin_reg[PW-1:0]) begin
          state_d = OPEN;
          fail_d  = '0;
        end else if (({1'b0, fail_cnt} + 3'd1) == MAXF3) begin
          state_d    = LOCKOUT;
          timer_load = 1'b1;
          err_d      = 1'b1;
          fail_d     = MAXF2;
        end else begin
          state_d = ENTRY;
          fail_d  = fail_cnt + 2'd1;
          err_d   = 1'b1;
        end
      end
      OPEN: begin
        if (keyboard_en) begin
          if ((keyboard_num == KEY_STAR) || (keyboard_num == KEY_HASH)) begin
            state_d = ENTRY;
          end
`ifdef PIN_LOCK_PIN_CHANGE_EN
          else if (keyboard_num == KEY_CHG) begin
            state_d = NEWPIN;
          end
`endif
        end
      end
      LOCKOUT: begin
        if (timer_done) begin
          state_d = ENTRY;
          fail_d  = '0;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

endmodule
